// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// drain default and the bundle of per-stage control strobes.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN         = 2'd0,
      ST_MULDIV_WAIT = 2'd1,
      ST_TRAP_DRAIN  = 2'd2,
      ST_ILLEGAL     = 2'd3
   } ctrl_state_e;

   localparam int DRAIN_CYCLES_DEF = 2;

   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic idex_stall;
      logic exmem_stall;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_bubble;
      logic memwb_bubble;
      logic muldiv_start;
      logic trap_ack;
   } ctrl_out_t;

endpackage

// File: rtl/pipeline_ctrl_unit_stall_perf_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module stall_perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control FSM: arbitrates memory freeze, MUL/DIV waits, trap drain,
// branch flushes and load-use stalls into per-stage stall/flush/bubble strobes.
module pipeline_ctrl_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_use_i,
   input  logic             dmem_busy_i,
   input  logic             muldiv_req_i,
   input  logic             muldiv_done_i,
   input  logic             branch_taken_i,
   input  logic             trap_req_i,
   output logic             pc_stall_o,
   output logic             ifid_stall_o,
   output logic             idex_stall_o,
   output logic             exmem_stall_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             exmem_bubble_o,
   output logic             memwb_bubble_o,
   output logic             muldiv_start_o,
   output logic             trap_ack_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   ctrl_state_e   state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          pend_q, pend_d;
   ctrl_out_t     o;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      pend_d  = pend_q;
      o       = '0;

      if (dmem_busy_i) begin
         // Memory freeze overrides everything; only a finishing MUL/DIV is remembered.
         o.pc_stall     = 1'b1;
         o.ifid_stall   = 1'b1;
         o.idex_stall   = 1'b1;
         o.exmem_stall  = 1'b1;
         o.memwb_bubble = 1'b1;
         if ((state_q == ST_MULDIV_WAIT) && muldiv_done_i) begin
            pend_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (trap_req_i) begin
                  o.pc_stall    = 1'b1;
                  o.ifid_flush  = 1'b1;
                  o.idex_bubble = 1'b1;
                  state_d       = ST_TRAP_DRAIN;
                  drain_d       = DW'(DRAIN_CYCLES);
               end else if (muldiv_req_i) begin
                  o.muldiv_start = 1'b1;
                  o.pc_stall     = 1'b1;
                  o.ifid_stall   = 1'b1;
                  o.idex_stall   = 1'b1;
                  o.exmem_bubble = 1'b1;
                  state_d        = ST_MULDIV_WAIT;
               end else if (branch_taken_i) begin
                  o.ifid_flush  = 1'b1;
                  o.idex_bubble = 1'b1;
               end else if (load_use_i) begin
                  o.pc_stall    = 1'b1;
                  o.ifid_stall  = 1'b1;
                  o.idex_bubble = 1'b1;
               end
            end
            ST_MULDIV_WAIT: begin
               if (muldiv_done_i || pend_q) begin
                  state_d = ST_RUN;
                  pend_d  = 1'b0;
               end else begin
                  o.pc_stall     = 1'b1;
                  o.ifid_stall   = 1'b1;
                  o.idex_stall   = 1'b1;
                  o.exmem_bubble = 1'b1;
               end
            end
            ST_TRAP_DRAIN: begin
               o.pc_stall    = 1'b1;
               o.ifid_flush  = 1'b1;
               o.idex_bubble = 1'b1;
               if (drain_q == '0) begin
                  o.trap_ack = 1'b1;
                  state_d    = ST_RUN;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end

      if (reset_i) begin
         o = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         pend_q  <= pend_d;
      end
   end

   assign pc_stall_o     = o.pc_stall;
   assign ifid_stall_o   = o.ifid_stall;
   assign idex_stall_o   = o.idex_stall;
   assign exmem_stall_o  = o.exmem_stall;
   assign ifid_flush_o   = o.ifid_flush;
   assign idex_bubble_o  = o.idex_bubble;
   assign exmem_bubble_o = o.exmem_bubble;
   assign memwb_bubble_o = o.memwb_bubble;
   assign muldiv_start_o = o.muldiv_start;
   assign trap_ack_o     = o.trap_ack;
   assign state_o        = state_q;

   stall_perf_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk   (clk_i),
      .clear (reset_i),
      .inc   (o.pc_stall),
      .count (stall_cnt_o)
   );

endmodule
